// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the MEM-stage data-memory interface.
//   SIZE_BYTE / SIZE_WORD : req_size encodings (also used by the MEM stage)
//   state_e               : responder FSM state encodings
//   access_err()          : illegal size or misaligned word access
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Only byte accesses and even-aligned word accesses are legal.
  function automatic logic access_err(input logic [1:0] size, input logic addr_lsb);
    return !((size == SIZE_BYTE) || ((size == SIZE_WORD) && !addr_lsb));
  endfunction

endpackage

// File: rtl/byte_ram.sv
// byte_ram: two 8-bit lanes (even / odd byte addresses), each DEPTH_BYTES/2
// deep, with per-lane write enable, synchronous write and combinational read.
// No reset: the contents survive reset and power up unspecified.
//   clk                    : write clock
//   idx                    : shared lane index (byte address >> 1)
//   we_even, we_odd        : per-lane write enables
//   wdata_even, wdata_odd  : per-lane write data
//   rdata_even, rdata_odd  : per-lane read data at idx
module byte_ram #(
  parameter int DEPTH_BYTES = 1024,
  parameter int IDX_W       = 9
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] idx,
  input  logic             we_even,
  input  logic             we_odd,
  input  logic [7:0]       wdata_even,
  input  logic [7:0]       wdata_odd,
  output logic [7:0]       rdata_even,
  output logic [7:0]       rdata_odd
);

  localparam int LANE_DEPTH = DEPTH_BYTES / 2;

  logic [7:0] lane_even [LANE_DEPTH];
  logic [7:0] lane_odd  [LANE_DEPTH];

  always_ff @(posedge clk) begin
    if (we_even) lane_even[idx] <= wdata_even;
    if (we_odd)  lane_odd[idx]  <= wdata_odd;
  end

  assign rdata_even = lane_even[idx];
  assign rdata_odd  = lane_odd[idx];

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: responder end of the MEM-stage data-memory interface.
// Accepts one load/store at a time, waits WAIT_CYCLES extra cycles, performs
// the access on a little-endian byte store, and returns a one-cycle response.
//   clk, reset               : clock, async active-high reset
//   req_valid/wr/size/addr/wdata : request from the MEM stage
//   busy                     : access in progress, pipeline must stall
//   resp_valid               : one-cycle response pulse
//   resp_rdata, resp_err     : load data / error flag, held until next response
//
// state     | meaning
// ST_IDLE   | no access pending, request can be accepted
// ST_ACTIVE | request latched, counting down wait states
// ST_RESP   | response pulse cycle, a new request can be accepted
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        busy,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW         = $clog2(DEPTH_BYTES);
  localparam int LANE_DEPTH = DEPTH_BYTES / 2;
  localparam int IDX_W      = (AW > 1) ? AW - 1 : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        busy_q, busy_d;
  logic        resp_valid_q, resp_valid_d;
  logic [15:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic             accept;
  logic             err;
  logic [14:0]      idx_full;
  logic [IDX_W-1:0] idx;
  logic             we_even, we_odd;
  logic [7:0]       wdata_even, wdata_odd;
  logic [7:0]       rdata_even, rdata_odd;
  logic [15:0]      load_data;
  logic             unused_idx_bits;

  // Address wraps modulo DEPTH_BYTES: bit 0 selects the lane, the next
  // AW-1 bits index both lanes; everything above is ignored.
  assign idx_full        = addr_q[15:1];
  assign idx             = idx_full[IDX_W-1:0] & IDX_W'(LANE_DEPTH - 1);
  assign unused_idx_bits = |(idx_full >> IDX_W);

  assign err = access_err(size_q, addr_q[0]);

  always_comb begin
    if (size_q == SIZE_WORD) load_data = {rdata_odd, rdata_even};
    else                     load_data = {8'h00, addr_q[0] ? rdata_odd : rdata_even};
  end

  // Byte stores go to the lane picked by addr[0], always from wdata[7:0].
  always_comb begin
    wdata_even = wdata_q[7:0];
    wdata_odd  = (size_q == SIZE_WORD) ? wdata_q[15:8] : wdata_q[7:0];
  end

  assign accept = req_valid && ((state_q == ST_IDLE) || (state_q == ST_RESP));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_d         = wr_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    we_even      = 1'b0;
    we_odd       = 1'b0;

    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (accept) begin
          state_d = ST_ACTIVE;
          cnt_d   = WAIT_INIT;
          wr_d    = req_wr;
          size_d  = req_size;
          addr_d  = req_addr;
          wdata_d = req_wdata;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = err;
          resp_rdata_d = (!err && !wr_q) ? load_data : 16'h0000;
          // Store commits on the ACTIVE->RESP edge; errors never touch memory.
          if (wr_q && !err) begin
            if (size_q == SIZE_WORD) begin
              we_even = 1'b1;
              we_odd  = 1'b1;
            end else begin
              we_even = !addr_q[0];
              we_odd  = addr_q[0];
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_ACTIVE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      wr_q         <= 1'b0;
      size_q       <= 2'b00;
      addr_q       <= 16'h0000;
      wdata_q      <= 16'h0000;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 16'h0000;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  byte_ram #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .IDX_W       (IDX_W)
  ) u_ram (
    .clk        (clk),
    .idx        (idx),
    .we_even    (we_even),
    .we_odd     (we_odd),
    .wdata_even (wdata_even),
    .wdata_odd  (wdata_odd),
    .rdata_even (rdata_even),
    .rdata_odd  (rdata_odd)
  );

  assign busy       = busy_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule
